instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage feeding the control decoder: owns the program counter and
//  addresses the combinational instruction ROM. Holds the fetched word in an
//  instruction register (IR) whose top OP_W bits drive the decoder's ALUOp.
//  Redirects the PC when the decoder/ALU resolve a taken branch, inserting
//  one bubble. Runs a Start/Done program-level handshake.
// PARAMETERS
//  PC_W      10       PC / ROM address width
//  INSTR_W   9        instruction word width
//  OP_W      3        opcode field width, IR[INSTR_W-1 -: OP_W]
//  HALT_INSTR 9'h1FF  instruction word that ends the program
//  CNT_W     16       cycle counter width
// PORTS
//  Clk        in   1        clock, all state on rising edge
//  Reset      in   1        synchronous, active-high; priority over all inputs
//  Start      in   1        1 = load StartAddr and hold; 1->0 begins execution
//  StartAddr  in   PC_W     first instruction address
//  Stall      in   1        1 = freeze PC, IR, InstrValid (counter still runs)
//  Jump       in   1        taken branch for the instruction currently in IR
//  TargRel    in   1        1 = Target is signed offset from IrPC; 0 = absolute
//  Target     in   PC_W     branch target / offset
//  InstrIn    in   INSTR_W  ROM data, combinational read of ROM[PC]
//  PC         out  PC_W     fetch address to ROM
//  Instr      out  INSTR_W  IR contents
//  Opcode     out  OP_W     IR opcode field, to decoder ALUOp
//  IrPC       out  PC_W     address of the instruction in IR
//  InstrValid out  1        IR holds a live instruction (0 = bubble)
//  Done       out  1        program halted
//  CycleCount out  CNT_W    cycles spent in RUN
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, Instr=0, IrPC=0, InstrValid=0, Done=0, CycleCount=0.
//  FSM states IDLE, LOAD, RUN, DONE:
//   IDLE: Start=1 -> LOAD. Outputs hold.
//   LOAD: PC<=StartAddr, InstrValid<=0, Done<=0, CycleCount<=0 every cycle
//         while Start=1; Start=0 -> RUN (first fetch at StartAddr in RUN).
//   RUN:  see pipeline rules below; halt detected -> DONE.
//   DONE: Done=1, PC/IR/CycleCount frozen, InstrValid=0; Start=1 -> LOAD.
//  Start=1 in RUN aborts: -> LOAD next cycle (IR invalidated).
//  RUN pipeline, per edge, priority order:
//   1 Stall=1: PC, Instr, IrPC, InstrValid hold; Jump ignored.
//   2 InstrValid=1 & Instr==HALT_INSTR: -> DONE; no fetch; Jump ignored.
//   3 InstrValid=1 & Jump=1: PC<=tgt; InstrValid<=0 (one bubble; word
//     fetched from PC discarded). tgt = TargRel ? IrPC+$signed(Target)
//     : Target, mod 2^PC_W.
//   4 otherwise: Instr<=InstrIn, IrPC<=PC, InstrValid<=1, PC<=PC+1 mod 2^PC_W.
//  Jump with InstrValid=0 is ignored (bubble cannot branch).
//  Fetch latency: word at address A appears on Instr one edge after PC=A.
//  Taken-branch penalty: exactly one bubble cycle.
//  CycleCount increments every RUN cycle incl. stalls, saturates at all-ones.
//  Opcode = Instr[INSTR_W-1 -: OP_W] always (combinational, even if invalid).
// TESTING
//  1 Reset, Start=1 StartAddr=0x010 2 cyc, Start=0, ROM = non-halt words ->
//    IrPC 0x010,0x011,0x012.. on consecutive cycles, InstrValid=1 from the
//    2nd RUN edge.
//  2 IR at 0x020, Jump=1 TargRel=0 Target=0x005 -> next cycle
//    InstrValid=0, PC=0x005; following cycle IrPC=0x005.
//  3 IR at 0x003, Jump=1 TargRel=1 Target=-4 (0x3FC) -> PC=0x3FF
//    (wrap); then PC 0x3FF -> IrPC 0x3FF, PC wraps to 0x000.
//  4 Stall=1 for 3 cycles with Jump=1 held -> PC/IR unchanged, CycleCount +3;
//    Stall drops -> jump taken on the first unstalled edge.
//  5 HALT_INSTR at 0x008 -> when IrPC=0x008, next cycle Done=1, PC frozen,
//    CycleCount frozen; Start=1 -> Done=0, CycleCount=0 in LOAD.
//  6 Reset=1 mid-RUN with Jump=1 and Stall=1 -> all outputs at reset values
//    next edge, state IDLE.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the control decoder.
//
// Owns the program counter, addresses a combinational instruction ROM and
// latches the returned word into the instruction register (IR). A taken
// branch resolved for the instruction in IR redirects the PC and costs one
// bubble. A Start/Done handshake frames each program run.
//
// Ports:
//   Clk        in   clock, all state updates on the rising edge
//   Reset      in   synchronous active-high reset, overrides every other input
//   Start      in   1 = load StartAddr and hold; falling to 0 begins execution
//   StartAddr  in   address of the first instruction
//   Stall      in   freeze PC/IR/InstrValid (cycle counter keeps running)
//   Jump       in   taken branch for the instruction currently in IR
//   TargRel    in   1 = Target is a signed offset from IrPC, 0 = absolute
//   Target     in   branch target or offset
//   InstrIn    in   ROM data for address PC
//   PC         out  fetch address to the ROM
//   Instr      out  IR contents
//   Opcode     out  IR opcode field, drives the decoder's ALUOp
//   IrPC       out  address of the instruction held in IR
//   InstrValid out  IR holds a live instruction (0 = bubble)
//   Done       out  program has halted
//   CycleCount out  cycles spent running, saturating
module instr_fetch #(
    parameter int unsigned          PC_W       = 10,
    parameter int unsigned          INSTR_W    = 9,
    parameter int unsigned          OP_W       = 3,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = {INSTR_W{1'b1}},
    parameter int unsigned          CNT_W      = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    input  logic               Stall,
    input  logic               Jump,
    input  logic               TargRel,
    input  logic [PC_W-1:0]    Target,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] Instr,
    output logic [OP_W-1:0]    Opcode,
    output logic [PC_W-1:0]    IrPC,
    output logic               InstrValid,
    output logic               Done,
    output logic [CNT_W-1:0]   CycleCount
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PC_W-1:0]    branch_tgt;
    logic               is_halt;

    // Two's-complement add: a signed offset and an unsigned sum wrap identically.
    assign branch_tgt = TargRel ? (ir_pc_q + Target) : Target;
    assign is_halt    = valid_q && (instr_q == HALT_INSTR);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ir_pc_d = ir_pc_q;
        valid_d = valid_q;
        done_d  = done_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = StRun;
                end
            end

            StRun: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (Start) begin
                    // Abort: back to LOAD, current IR contents are dead.
                    state_d = StLoad;
                    valid_d = 1'b0;
                end else if (Stall) begin
                    // Hold everything but the counter.
                end else if (is_halt) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (valid_q && Jump) begin
                    // Word currently on InstrIn is on the wrong path: drop it.
                    pc_d    = branch_tgt;
                    valid_d = 1'b0;
                end else begin
                    instr_d = InstrIn;
                    ir_pc_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_W'(1);
                end
            end

            StDone: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
                if (Start) begin
                    state_d = StLoad;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            ir_pc_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ir_pc_q <= ir_pc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PC         = pc_q;
    assign Instr      = instr_q;
    assign Opcode     = instr_q[INSTR_W-1 -: OP_W];
    assign IrPC       = ir_pc_q;
    assign InstrValid = valid_q;
    assign Done       = done_q;
    assign CycleCount = cnt_q;

endmodule
